// File: rtl/dps_rx_23.sv
// Receive end of the 23-TSV DPS crosstalk-avoidance link: capture, pattern and range check,
// Fibonacci decode, small output FIFO and saturating link-quality statistics.
module dps_rx_23 #(
    parameter int TSV_W      = 23,
    parameter int DATA_W     = 17,
    parameter int NUM_CODES  = 92736,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [TSV_W-1:0]  tsv,
    input  logic              tsv_valid,
    output logic              tsv_ready,
    output logic [DATA_W-1:0] data_out,
    output logic              out_err,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic              clr_stats,
    output logic [CNT_W-1:0]  word_cnt,
    output logic [CNT_W-1:0]  err_cnt,
    output logic              err_sticky
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [DATA_W-1:0] CODE_LIMIT = DATA_W'(NUM_CODES);

    // DPS_dec_23: each transition between adjacent wires carries a Fibonacci weight
    // (1,2,3,5,...); the top wire selects the upper half of the code space.
    function automatic logic [DATA_W-1:0] dpsDec23(input logic [TSV_W-1:0] w);
        logic [DATA_W-1:0] acc;
        logic [DATA_W-1:0] fa;
        logic [DATA_W-1:0] fb;
        logic [DATA_W-1:0] fn;
        acc = '0;
        fa  = DATA_W'(1);
        fb  = DATA_W'(2);
        for (int k = 0; k < TSV_W - 1; k++) begin
            if (w[k] ^ w[k+1]) acc = acc + fa;
            fn = fa + fb;
            fa = fb;
            fb = fn;
        end
        if (w[TSV_W-1]) acc = acc + fa;
        return acc;
    endfunction

    logic [TSV_W-1:0]  r_s1Tsv;
    logic              r_s1Valid;
    logic [DATA_W:0]   r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wrPtr;
    logic [PTR_W-1:0]  r_rdPtr;
    logic [OCC_W-1:0]  r_count;
    logic [DATA_W-1:0] r_lastData;
    logic              r_lastErr;
    logic [CNT_W-1:0]  r_wordCnt;
    logic [CNT_W-1:0]  r_errCnt;
    logic              r_errSticky;

    logic [TSV_W-2:0]  w_trans;
    logic              w_patErr;
    logic [DATA_W-1:0] w_dec;
    logic              w_rngErr;
    logic              w_err;
    logic              w_accept;
    logic              w_push;
    logic              w_pop;

    // A 101/010 window is exactly two consecutive wire transitions.
    assign w_trans  = r_s1Tsv[TSV_W-2:0] ^ r_s1Tsv[TSV_W-1:1];
    assign w_patErr = |(w_trans[TSV_W-3:0] & w_trans[TSV_W-2:1]);
    assign w_dec    = dpsDec23(r_s1Tsv);
    assign w_rngErr = (w_dec >= CODE_LIMIT);
    assign w_err    = w_patErr | w_rngErr;

    assign tsv_ready = (r_count + OCC_W'(r_s1Valid)) < OCC_W'(FIFO_DEPTH);
    assign w_accept  = tsv_valid && tsv_ready;
    assign w_push    = r_s1Valid;
    assign out_valid = (r_count != '0);
    assign w_pop     = out_valid && out_ready;

    assign data_out   = out_valid ? r_mem[r_rdPtr][DATA_W:1] : r_lastData;
    assign out_err    = out_valid ? r_mem[r_rdPtr][0] : r_lastErr;
    assign word_cnt   = r_wordCnt;
    assign err_cnt    = r_errCnt;
    assign err_sticky = r_errSticky;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_s1Valid <= 1'b0;
            r_s1Tsv   <= '0;
        end else begin
            r_s1Valid <= w_accept;
            if (w_accept) r_s1Tsv <= tsv;
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) r_mem[r_wrPtr] <= {w_dec, w_err};
    end

    // Reserving a slot for the stage-1 word in tsv_ready means a push never finds the FIFO full.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_count    <= '0;
            r_lastData <= '0;
            r_lastErr  <= 1'b0;
        end else begin
            if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
            if (w_pop) begin
                r_rdPtr    <= r_rdPtr + 1'b1;
                r_lastData <= r_mem[r_rdPtr][DATA_W:1];
                r_lastErr  <= r_mem[r_rdPtr][0];
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wordCnt   <= '0;
            r_errCnt    <= '0;
            r_errSticky <= 1'b0;
        end else if (clr_stats) begin
            r_wordCnt   <= '0;
            r_errCnt    <= '0;
            r_errSticky <= 1'b0;
        end else if (w_push) begin
            if (r_wordCnt != '1) r_wordCnt <= r_wordCnt + 1'b1;
            if (w_err && (r_errCnt != '1)) r_errCnt <= r_errCnt + 1'b1;
            r_errSticky <= r_errSticky | w_err;
        end
    end

endmodule

// File: tb/tb_dps_rx_23.sv
// Randomised and directed bench for dps_rx_23, checked against an encoder/scoreboard model.
module tb_dps_rx_23;

    logic        clock = 1'b0;
    logic        reset;
    logic [22:0] tsv;
    logic        tsv_valid;
    logic        out_ready;
    logic        clr_stats;

    logic        tsv_ready;
    logic [16:0] data_out;
    logic        out_err;
    logic        out_valid;
    logic [15:0] word_cnt;
    logic [15:0] err_cnt;
    logic        err_sticky;

    logic        satTsvReady;
    logic [16:0] satDataOut;
    logic        satOutErr;
    logic        satOutValid;
    logic [3:0]  satWordCnt;
    logic [3:0]  satErrCnt;
    logic        satErrSticky;

    dps_rx_23 u_dut (
        .clock(clock), .reset(reset), .tsv(tsv), .tsv_valid(tsv_valid), .tsv_ready(tsv_ready),
        .data_out(data_out), .out_err(out_err), .out_valid(out_valid), .out_ready(out_ready),
        .clr_stats(clr_stats), .word_cnt(word_cnt), .err_cnt(err_cnt), .err_sticky(err_sticky)
    );

    dps_rx_23 #(.CNT_W(4)) u_dutSat (
        .clock(clock), .reset(reset), .tsv(tsv), .tsv_valid(tsv_valid), .tsv_ready(satTsvReady),
        .data_out(satDataOut), .out_err(satOutErr), .out_valid(satOutValid), .out_ready(out_ready),
        .clr_stats(clr_stats), .word_cnt(satWordCnt), .err_cnt(satErrCnt), .err_sticky(satErrSticky)
    );

    always #5 clock = ~clock;

    typedef struct {
        int unsigned data;
        bit          err;
        bit          chk;
    } exp_t;

    exp_t expQ[$];
    exp_t curExp;
    int   numCompared   = 0;
    int   numMismatched = 0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        numCompared++;
        if (got !== want) begin
            numMismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, want, $time);
        end
    endtask

    // Greedy Zeckendorf encoding of the low half, top wire picks the half,
    // wires then follow the transition pattern downward.
    function automatic logic [22:0] encode(input int unsigned v);
        int unsigned fib[22];
        int unsigned rem;
        logic [21:0] d;
        logic [22:0] s;
        fib[0] = 1;
        fib[1] = 2;
        for (int k = 2; k < 22; k++) fib[k] = fib[k-1] + fib[k-2];
        s[22] = (v >= 46368);
        rem   = s[22] ? v - 46368 : v;
        d     = '0;
        for (int k = 21; k >= 0; k--) begin
            if (rem >= fib[k]) begin
                d[k] = 1'b1;
                rem  = rem - fib[k];
            end
        end
        for (int k = 21; k >= 0; k--) s[k] = s[k+1] ^ d[k];
        return s;
    endfunction

    function automatic bit hasForbidden(input logic [22:0] w);
        logic [2:0] t;
        for (int j = 0; j <= 20; j++) begin
            t = w[j +: 3];
            if (t == 3'b101 || t == 3'b010) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic applyStimulus(input bit valid, input logic [22:0] word,
                                 input int unsigned expData, input bit chk);
        tsv_valid  = valid;
        tsv        = word;
        curExp.data = expData;
        curExp.err  = hasForbidden(word);
        curExp.chk  = chk && !curExp.err;
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        tsv_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic doReset();
        tsv_valid = 1'b0;
        clr_stats = 1'b0;
        out_ready = 1'b1;
        reset     = 1'b1;
        @(posedge clock);
        #1;
        expQ.delete();
        reset = 1'b0;
        @(posedge clock);
        #1;
    endtask

    // Scoreboard: every handshake seen just before an edge is modelled at that edge.
    always @(negedge clock) begin
        exp_t e;
        if (!reset) begin
            if (out_valid && out_ready) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedPop", 32'(out_valid), 32'd0);
                end else begin
                    e = expQ.pop_front();
                    if (e.chk) checkOutput("headData", 32'(data_out), e.data);
                    checkOutput("headErr", 32'(out_err), 32'(e.err));
                end
            end
            if (tsv_valid && tsv_ready) expQ.push_back(curExp);
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int unsigned v;
        int          accepted;
        bit          wasReady;
        bit          goValid;
        bit          pending;
        bit          chk;
        logic [22:0] w;
        int          nWords;
        int          nErr;
        int          cycles;

        reset     = 1'b1;
        tsv       = '0;
        tsv_valid = 1'b0;
        out_ready = 1'b1;
        clr_stats = 1'b0;
        @(posedge clock);
        #1;
        checkOutput("rstOutValid", 32'(out_valid), 32'd0);
        checkOutput("rstDataOut", 32'(data_out), 32'd0);
        checkOutput("rstOutErr", 32'(out_err), 32'd0);
        checkOutput("rstWordCnt", 32'(word_cnt), 32'd0);
        checkOutput("rstErrCnt", 32'(err_cnt), 32'd0);
        checkOutput("rstSticky", 32'(err_sticky), 32'd0);
        checkOutput("rstTsvReady", 32'(tsv_ready), 32'd1);
        reset = 1'b0;
        @(posedge clock);
        #1;

        $display("[TB] round trip");
        applyStimulus(1'b1, encode(0), 0, 1'b1);
        checkOutput("t1NotYetValid", 32'(out_valid), 32'd0);
        applyStimulus(1'b1, encode(356), 356, 1'b1);
        checkOutput("t1FirstValid", 32'(out_valid), 32'd1);
        checkOutput("t1FirstData", 32'(data_out), 32'd0);
        applyStimulus(1'b1, encode(92735), 92735, 1'b1);
        idle(4);
        checkOutput("t1WordCnt", 32'(word_cnt), 32'd3);
        checkOutput("t1ErrCnt", 32'(err_cnt), 32'd0);
        checkOutput("t1Sticky", 32'(err_sticky), 32'd0);
        checkOutput("t1Drained", 32'(expQ.size()), 32'd0);
        checkOutput("t1HoldData", 32'(data_out), 32'd92735);

        $display("[TB] pattern error");
        doReset();
        applyStimulus(1'b1, 23'h000005, 0, 1'b0);
        applyStimulus(1'b1, 23'h7FFFFF, 46368, 1'b1);
        checkOutput("t2ErrHead", 32'(out_err), 32'd1);
        idle(1);
        checkOutput("t2CleanErr", 32'(out_err), 32'd0);
        checkOutput("t2CleanData", 32'(data_out), 32'd46368);
        idle(2);
        checkOutput("t2ErrCnt", 32'(err_cnt), 32'd1);
        checkOutput("t2Sticky", 32'(err_sticky), 32'd1);
        checkOutput("t2WordCnt", 32'(word_cnt), 32'd2);

        $display("[TB] backpressure");
        doReset();
        out_ready = 1'b0;
        accepted  = 0;
        v         = 100;
        for (int i = 0; i < 8; i++) begin
            wasReady = tsv_ready;
            applyStimulus(1'b1, encode(v), v, 1'b1);
            if (wasReady) begin
                accepted++;
                v = v + 1111;
            end
        end
        checkOutput("t3Accepted", 32'(accepted), 32'd4);
        checkOutput("t3ReadyLow", 32'(tsv_ready), 32'd0);
        checkOutput("t3HeadData", 32'(data_out), 32'd100);
        tsv_valid = 1'b0;
        out_ready = 1'b1;
        idle(6);
        checkOutput("t3Drained", 32'(expQ.size()), 32'd0);
        checkOutput("t3ReadyBack", 32'(tsv_ready), 32'd1);
        checkOutput("t3Empty", 32'(out_valid), 32'd0);
        checkOutput("t3WordCnt", 32'(word_cnt), 32'd4);

        $display("[TB] saturation and clear");
        doReset();
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, encode(i * 4000), i * 4000, 1'b1);
        idle(3);
        checkOutput("t4SatWordCnt", 32'(satWordCnt), 32'd15);
        checkOutput("t4WordCnt", 32'(word_cnt), 32'd20);
        checkOutput("t4SatErrCnt", 32'(satErrCnt), 32'd0);
        applyStimulus(1'b1, 23'h000005, 0, 1'b0);
        tsv_valid = 1'b0;
        clr_stats = 1'b1;
        @(posedge clock);
        #1;
        clr_stats = 1'b0;
        checkOutput("t4ClrWordCnt", 32'(word_cnt), 32'd0);
        checkOutput("t4ClrErrCnt", 32'(err_cnt), 32'd0);
        checkOutput("t4ClrSticky", 32'(err_sticky), 32'd0);
        checkOutput("t4ClrSatWordCnt", 32'(satWordCnt), 32'd0);
        checkOutput("t4ClrSatSticky", 32'(satErrSticky), 32'd0);
        idle(3);
        checkOutput("t4ClrDrained", 32'(expQ.size()), 32'd0);

        $display("[TB] reset mid-stream");
        doReset();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, encode(500 + i), 500 + i, 1'b1);
        tsv_valid = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        checkOutput("t5OutValid", 32'(out_valid), 32'd0);
        checkOutput("t5WordCnt", 32'(word_cnt), 32'd0);
        checkOutput("t5DataOut", 32'(data_out), 32'd0);
        checkOutput("t5Ready", 32'(tsv_ready), 32'd1);
        expQ.delete();
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;
        out_ready = 1'b1;
        applyStimulus(1'b1, encode(1234), 1234, 1'b1);
        tsv_valid = 1'b0;
        checkOutput("t5NotYet", 32'(out_valid), 32'd0);
        @(posedge clock);
        #1;
        checkOutput("t5Valid", 32'(out_valid), 32'd1);
        checkOutput("t5Data", 32'(data_out), 32'd1234);
        @(posedge clock);
        #1;
        checkOutput("t5Alone", 32'(out_valid), 32'd0);
        checkOutput("t5WordCnt1", 32'(word_cnt), 32'd1);

        $display("[TB] random traffic");
        doReset();
        nWords  = 0;
        nErr    = 0;
        cycles  = 0;
        pending = 1'b0;
        v       = 0;
        chk     = 1'b0;
        w       = '0;
        while (nWords < 3000 && cycles < 20000) begin
            if (!pending) begin
                if ($urandom_range(0, 7) == 0) begin
                    w   = 23'($urandom);
                    v   = 0;
                    chk = 1'b0;
                end else begin
                    v   = $urandom_range(0, 92735);
                    w   = encode(v);
                    chk = 1'b1;
                end
                pending = 1'b1;
            end
            goValid   = ($urandom_range(0, 9) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            wasReady  = tsv_ready;
            applyStimulus(goValid, w, v, chk);
            if (goValid && wasReady) begin
                pending = 1'b0;
                nWords++;
                if (hasForbidden(w)) nErr++;
            end
            cycles++;
        end
        checkOutput("t6Budget", 32'(nWords), 32'd3000);
        out_ready = 1'b1;
        idle(8);
        checkOutput("t6Drained", 32'(expQ.size()), 32'd0);
        checkOutput("t6WordCnt", 32'(word_cnt), 32'(nWords));
        checkOutput("t6ErrCnt", 32'(err_cnt), 32'(nErr));
        checkOutput("t6Sticky", 32'(err_sticky), 32'(nErr != 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
        $finish;
    end

endmodule
